clut_fade_ctrl: RTL and testbench

- Sequencer that loads a colour lookup table (CLUT) from a source palette memory, applying a brightness fade as it goes.
- Reads entries 0..2^CIDXW-1 from a 1-cycle-latency source BRAM, scales each RGB channel by a fade level, and writes the result through the CLUT write port.
- Sits between the frame/animation logic (which issues start and level) and the CLUT write side. Typically started once per frame during blanking.

---
 rtl/clut_fade_ctrl.sv | 123 ++++++++++++
 tb/tb_clut_fade_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/clut_fade_ctrl.sv
// rtl/clut_fade_ctrl.sv - CLUT loader that streams a source palette through a brightness fade.
// Optional build macro CLUT_FADE_ROUND_EN selects round-to-nearest channel scaling.
module clut_fade_ctrl #(
    parameter int COLRW = 12,
    parameter int CIDXW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       fade_level,
    output logic [CIDXW-1:0] src_addr,
    input  logic [COLRW-1:0] src_data,
    output logic             we,
    output logic [CIDXW-1:0] cidx_write,
    output logic [COLRW-1:0] colr_in,
    output logic             busy,
    output logic             done
);
    localparam int CHW = COLRW / 3;
    localparam int N   = 1 << CIDXW;
    localparam logic [CIDXW-1:0] LAST_IDX = CIDXW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CIDXW-1:0] addr_q, addr_d;
    logic             vld_q, vld_d;
    logic [CIDXW-1:0] idx_q, idx_d;
    logic [4:0]       level_q, level_d;
    logic             we_q, we_d;
    logic [CIDXW-1:0] cidx_q, cidx_d;
    logic [COLRW-1:0] colr_q, colr_d;

    // Level never exceeds 16, so the CHW+5-bit product (plus rounding) cannot overflow.
    function automatic logic [CHW-1:0] scale_ch(input logic [CHW-1:0] ch, input logic [4:0] lvl);
        logic [CHW+4:0] prod;
        prod = {5'd0, ch} * {{CHW{1'b0}}, lvl};
`ifdef CLUT_FADE_ROUND_EN
        prod = prod + (CHW+5)'(8);
`endif
        return CHW'(prod >> 4);
    endfunction

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        vld_d   = 1'b0;
        idx_d   = idx_q;
        level_d = level_q;
        we_d    = 1'b0;
        cidx_d  = cidx_q;
        colr_d  = colr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    addr_d  = '0;
                    level_d = (fade_level > 5'd16) ? 5'd16 : fade_level;
                end
            end
            S_RUN: begin
                vld_d = 1'b1;
                idx_d = addr_q;
                if (addr_q == LAST_IDX) begin
                    state_d = S_FLUSH;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_FLUSH: begin
                if (!vld_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // vld_q marks the cycle in which src_data holds the entry addressed one cycle earlier.
        if (vld_q) begin
            we_d   = 1'b1;
            cidx_d = idx_q;
            colr_d = {scale_ch(src_data[COLRW-1 -: CHW], level_q),
                      scale_ch(src_data[2*CHW-1 -: CHW], level_q),
                      scale_ch(src_data[CHW-1:0], level_q)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
            level_q <= '0;
            we_q    <= 1'b0;
            cidx_q  <= '0;
            colr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
            level_q <= level_d;
            we_q    <= we_d;
            cidx_q  <= cidx_d;
            colr_q  <= colr_d;
        end
    end

    assign src_addr   = addr_q;
    assign we         = we_q;
    assign cidx_write = cidx_q;
    assign colr_in    = colr_q;
    assign busy       = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_clut_fade_ctrl.sv
// tb/tb_clut_fade_ctrl.sv - self-checking bench for clut_fade_ctrl against a per-cycle palette model.
module tb_clut_fade_ctrl;
    localparam int COLRW = 12;
    localparam int CIDXW = 4;
    localparam int N     = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [4:0]       fade_level = 5'd0;
    logic [CIDXW-1:0] src_addr;
    logic [COLRW-1:0] src_data;
    logic             we;
    logic [CIDXW-1:0] cidx_write;
    logic [COLRW-1:0] colr_in;
    logic             busy;
    logic             done;

    logic [COLRW-1:0] mem [N];
    logic [COLRW-1:0] exp_colr = '0;
    logic [CIDXW-1:0] exp_cidx = '0;
    int n_cmp = 0;
    int n_bad = 0;

    clut_fade_ctrl #(.COLRW(COLRW), .CIDXW(CIDXW)) dut (
        .clk(clk), .rst(rst), .start(start), .fade_level(fade_level),
        .src_addr(src_addr), .src_data(src_data), .we(we),
        .cidx_write(cidx_write), .colr_in(colr_in), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Source palette BRAM: one cycle read latency.
    always @(posedge clk) src_data <= mem[src_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Each 4-bit channel scaled by the clamped level with integer arithmetic.
    function automatic logic [COLRW-1:0] model(input logic [COLRW-1:0] col, input int lvl);
        int L;
        int r;
        int v;
        logic [COLRW-1:0] res;
        L = (lvl > 16) ? 16 : lvl;
        r = 0;
`ifdef CLUT_FADE_ROUND_EN
        r = 8;
`endif
        res = '0;
        for (int i = 0; i < 3; i++) begin
            v = int'((col >> (4 * i)) & 12'hF);
            res[4*i +: 4] = 4'((v * L + r) / 16);
        end
        return res;
    endfunction

    task automatic fill_const(input logic [COLRW-1:0] val);
        for (int i = 0; i < N; i++) mem[i] = val;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < N; i++) mem[i] = COLRW'(i * 12'h111);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < N; i++) mem[i] = COLRW'($urandom);
    endtask

    // Called just after a falling edge; start is sampled at the next rising edge (edge T).
    // Cycle c is the c-th cycle after T; extra starts are driven for cycles s1/s2.
    task automatic run_load(input int lvl, input int s1, input int s2, input int chg_at, input int rst_at);
        bit wr;
        start = 1'b1;
        fade_level = 5'(lvl);
        @(posedge clk);
        for (int c = 1; c <= N + 4; c++) begin
            @(negedge clk);
            if (rst_at > 0 && c > rst_at) begin
                exp_colr = '0;
                exp_cidx = '0;
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_we", 32'(we), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_colr", 32'(colr_in), 32'(exp_colr));
                check("rst_cidx", 32'(cidx_write), 32'(exp_cidx));
            end else begin
                wr = (c >= 3) && (c <= N + 2);
                if (wr) begin
                    exp_cidx = CIDXW'(c - 3);
                    exp_colr = model(mem[c-3], lvl);
                end
                check("busy", 32'(busy), 32'(c <= N + 2));
                check("done", 32'(done), 32'(c == N + 3));
                check("we", 32'(we), 32'(wr));
                check("cidx", 32'(cidx_write), 32'(exp_cidx));
                check("colr", 32'(colr_in), 32'(exp_colr));
                if (c <= N) check("src_addr", 32'(src_addr), 32'(c - 1));
            end
            start = (c == s1) || (c == s2);
            if (c == chg_at) fade_level = (lvl == 0) ? 5'd16 : 5'd0;
            rst = (rst_at > 0) && (c == rst_at);
        end
        start = 1'b0;
    endtask

    initial begin
        fill_ramp();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_we", 32'(we), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_cidx", 32'(cidx_write), 32'd0);
        check("reset_colr", 32'(colr_in), 32'd0);
        check("reset_addr", 32'(src_addr), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        fill_ramp();
        run_load(16, 0, 0, 0, 0);
        repeat (2) @(negedge clk);

        fill_const(12'hFFF);
        run_load(8, 0, 0, 0, 0);
        @(negedge clk);

        fill_rand();
        run_load(0, 0, 0, 0, 0);

        fill_ramp();
        run_load(20, 0, 0, 0, 0);
        @(negedge clk);

        fill_const(12'h5A3);
        run_load(4, 0, 0, 0, 0);
        @(negedge clk);

        // Starts while busy and in the DONE cycle are dropped; the next one is back-to-back.
        fill_rand();
        run_load(int'($urandom_range(0, 31)), 5, N + 3, 0, 0);
        run_load(int'($urandom_range(0, 31)), 0, 0, 0, 0);
        @(negedge clk);

        fill_rand();
        run_load(16, 0, 0, 6, 0);
        @(negedge clk);

        fill_rand();
        run_load(16, 0, 0, 0, 8);
        repeat (3) @(negedge clk);
        run_load(16, 0, 0, 0, 0);
        @(negedge clk);

        for (int t = 0; t < 6; t++) begin
            fill_rand();
            run_load(int'($urandom_range(0, 31)), int'($urandom_range(0, N + 3)), 0,
                     int'($urandom_range(1, N)), 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
